// File: rtl/conv_accumulator_if.sv
// Handshake bundle between the split-capable adder stream and the window-sum consumer.
interface conv_accumulator_if;
  localparam int unsigned DATA_W = 48;

  logic              lane_mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_ovf;
  logic              err_len;

  modport master (
    output lane_mode, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, err_len
  );

  modport slave (
    input  lane_mode, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf, err_len
  );
endinterface

// File: rtl/conv_accumulator.sv
// Window accumulator: one 48-bit or two 24-bit signed lanes, sticky overflow, single-entry output.
// Define ACC_SAT_EN to clamp overflowing lanes instead of wrapping.
module conv_accumulator #(
  parameter int unsigned OUT_SHIFT = 0,
  parameter int unsigned MAX_TERMS = 1024
) (
  input logic               clk,
  input logic               rst,
  conv_accumulator_if.slave bus
);
  localparam int unsigned DATA_W = 48;
  localparam int unsigned LANE_W = 24;
  localparam int unsigned CNT_W  = $clog2(MAX_TERMS) + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACC = 1'b1} state_t;

  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_acc, w_acc_next;
  logic [1:0]        r_ovf, w_ovf_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_mode, w_mode;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data, w_out_data;
  logic [1:0]        r_out_ovf;
  logic              r_err, w_err;
  logic              w_emit, w_beat;
  logic [DATA_W-1:0] w_sum_full;
  logic [LANE_W-1:0] w_sum_lo, w_sum_hi;
  logic              w_ovf_full, w_ovf_lo, w_ovf_hi;

  // Full-width add with signed-overflow flag in the MSB of the result.
  function automatic logic [DATA_W:0] add_full(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    logic              o;
    s = a + b;
    o = (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
`ifdef ACC_SAT_EN
    if (o) s = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    return {o, s};
  endfunction

  function automatic logic [LANE_W:0] add_lane(input logic [LANE_W-1:0] a, input logic [LANE_W-1:0] b);
    logic [LANE_W-1:0] s;
    logic              o;
    s = a + b;
    o = (a[LANE_W-1] == b[LANE_W-1]) && (s[LANE_W-1] != a[LANE_W-1]);
`ifdef ACC_SAT_EN
    if (o) s = a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
`endif
    return {o, s};
  endfunction

  function automatic logic [DATA_W-1:0] shr_full(input logic [DATA_W-1:0] x);
    return DATA_W'($signed(x) >>> OUT_SHIFT);
  endfunction

  function automatic logic [LANE_W-1:0] shr_lane(input logic [LANE_W-1:0] x);
    return LANE_W'($signed(x) >>> OUT_SHIFT);
  endfunction

  // A stalled output blocks every input beat, so no sum is ever overwritten unread.
  assign bus.in_ready  = !(r_out_valid && !bus.out_ready);
  assign w_beat        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.err_len   = r_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_beat) w_state_next = bus.in_last ? ST_IDLE : ST_ACC;
  end

  always_comb begin
    w_mode = (r_state == ST_IDLE) ? bus.lane_mode : r_mode;
    {w_ovf_full, w_sum_full} = add_full(r_acc, bus.in_data);
    {w_ovf_lo, w_sum_lo}     = add_lane(r_acc[LANE_W-1:0], bus.in_data[LANE_W-1:0]);
    {w_ovf_hi, w_sum_hi}     = add_lane(r_acc[DATA_W-1:LANE_W], bus.in_data[DATA_W-1:LANE_W]);
    w_acc_next = r_acc;
    w_ovf_next = r_ovf;
    w_cnt_next = r_cnt;
    w_err      = 1'b0;
    w_emit     = 1'b0;
    if (w_beat) begin
      if (r_state == ST_IDLE) begin
        w_acc_next = bus.in_data;
        w_ovf_next = 2'b00;
        w_cnt_next = CNT_W'(1);
      end else begin
        if (r_mode) begin
          w_acc_next = {w_sum_hi, w_sum_lo};
          w_ovf_next = r_ovf | {w_ovf_hi, w_ovf_lo};
        end else begin
          w_acc_next = w_sum_full;
          w_ovf_next = r_ovf | {1'b0, w_ovf_full};
        end
        // Count saturates one past the limit so the error pulses once per window.
        w_err = (r_cnt == CNT_W'(MAX_TERMS));
        if (r_cnt <= CNT_W'(MAX_TERMS)) w_cnt_next = r_cnt + CNT_W'(1);
      end
      w_emit = bus.in_last;
    end
    w_out_data = w_mode ? {shr_lane(w_acc_next[DATA_W-1:LANE_W]), shr_lane(w_acc_next[LANE_W-1:0])}
                        : shr_full(w_acc_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_ovf       <= '0;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      r_ovf <= w_ovf_next;
      r_cnt <= w_cnt_next;
      r_err <= w_err;
      if (w_beat && (r_state == ST_IDLE)) r_mode <= bus.lane_mode;
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_out_data;
        r_out_ovf   <= w_ovf_next;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule
